alu_op_selector: RTL
====================

Name: alu_op_selector

Overview:
- Upstream front-end for the ALU. Conditions the raw push-button and switch inputs from the board and drives the ALU's operand inputs and 3-bit operation code.
- The button is synchronised and debounced. Each accepted press advances the op code through the eight ALU operations, wrapping from the last back to the first.
- Operand switches are synchronised and registered, so the ALU only ever sees clean, clock-aligned values.

Parameters:
- N, 4, operand width (matches the ALU width parameter)
- DEBOUNCE_CYCLES, 50000, number of consecutive stable clock cycles required to accept a button level change (minimum 2)
- REPEAT_CYCLES, 25000000, hold time before the first auto-repeat step and between later steps (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- click_raw  in  1  raw push-button, active-high, asynchronous, bouncy
- in1_raw  in  N  raw operand-1 switches, asynchronous
- in2_raw  in  N  raw operand-2 switches, asynchronous
- in1  out  N  synchronised operand 1 to the ALU
- in2  out  N  synchronised operand 2 to the ALU
- op  out  3  operation code to the ALU
- op_step  out  1  one-cycle pulse in the cycle op changes
- busy  out  1  high while a press is being debounced or held

Behaviour:
- Reset (rst==0 at a clk edge):
  - op=0 (add), in1=0, in2=0, op_step=0, busy=0.
  - All synchroniser flops, the debounce counter and the FSM clear; FSM goes to IDLE.
  - Reset asserted mid-press aborts the press. No op_step is produced until the button is seen released (IDLE requires the synchronised level to be 0 before arming).
- Op encoding: 0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor, 6 shl, 7 shr. Each step is op<=op+1 modulo 8, so 7 wraps to 0.
- Synchronisers:
  - click_raw, in1_raw and in2_raw each pass through a 2-flop synchroniser.
  - in1/in2 are the second flop stage: 2-cycle latency from the raw input, no debounce on the switches.
- Debounce counter: cnt counts cycles the synchronised click (click_s) has been stable at the value the current state is waiting for. Any mismatch clears cnt to 0.
- FSM:
  - IDLE: busy=0. If click_s==1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT: busy=1. If click_s==0, return to IDLE. If cnt reaches DEBOUNCE_CYCLES, go to HELD, pulse op_step and increment op in that same cycle.
  - HELD: busy=1. If click_s==0, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT: busy=1. If click_s==1, return to HELD. If cnt reaches DEBOUNCE_CYCLES, go to IDLE.
- Press latency: op changes exactly DEBOUNCE_CYCLES+2 cycles after click_raw rises and stays high (2 synchroniser cycles plus debounce).
- Exactly one op_step per accepted press, regardless of hold length or bounce on release.
- Glitches shorter than DEBOUNCE_CYCLES in any state cause no op change.
- op_step is never high for two consecutive cycles.
- Counter width is $clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)+1). The counter saturates and never wraps.

Optional Feature:
- Macro: ALU_OP_AUTOREPEAT_EN.
- Defined:
  - In HELD a second counter rcnt runs. When rcnt reaches REPEAT_CYCLES, op_step pulses, op increments (with wrap) and rcnt restarts at 0.
  - rcnt clears on leaving HELD and on reset.
- Undefined: no rcnt logic, HELD never steps op, and REPEAT_CYCLES is ignored.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10):
- Reset: hold rst=0 for 3 cycles with click_raw=1, in1_raw=5 -> op=0, in1=0, busy=0. After rst=1 with click still held, op stays 0 until click is released and pressed again.
- Clean press: click_raw 0->1 held for 20 cycles -> op 0->1 exactly 6 cycles after the rise, op_step high for 1 cycle, busy=1 until 4 stable-low cycles after release.
- Bounce: click toggles 1,0,1,0 with 2-cycle pulses, then held -> a single op_step, op=1. A 3-cycle isolated pulse -> no change.
- Wrap: 8 clean presses from reset -> op sequence 1,2,...,7,0, with 8 op_step pulses total.
- Operands: in1_raw=6, in2_raw=10 applied at cycle t -> in1=6, in2=10 at t+2, independent of button activity.
- Autorepeat (macro defined): hold click for 40 cycles -> op=1 at press acceptance, then +1 every 10 cycles while held (op=4 before release). With the macro undefined, the same hold gives op=1 only.

Source files
------------

// File: rtl/alu_op_selector.sv
// -----------------------------------------------------------------------------
// alu_op_selector
//   Board front-end for the ALU. The bouncy push-button is synchronised and
//   debounced, and each accepted press advances the 3-bit ALU op code
//   (add, sub, mul, and, or, xor, shl, shr, then back to add). The operand
//   switches are passed through 2-flop synchronisers, so the ALU only ever
//   sees clock-aligned values.
//
//   Optional build macro: ALU_OP_AUTOREPEAT_EN
//     When defined, holding the button steps the op code again every
//     REPEAT_CYCLES cycles. When undefined, a held button steps only once.
// -----------------------------------------------------------------------------
module alu_op_selector #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         click_raw,
    input  logic [N-1:0] in1_raw,
    input  logic [N-1:0] in2_raw,
    output logic [N-1:0] in1,
    output logic [N-1:0] in2,
    output logic [2:0]   op,
    output logic         op_step,
    output logic         busy
);

    // One counter width covers both the debounce and the repeat intervals.
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
    // The cycle that brings the stable count up to DEBOUNCE_CYCLES is the
    // one that commits, so the registered count is compared with one less.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Next op code; the 3-bit add wraps shr (7) back to add (0).
    function automatic logic [2:0] op_next(input logic [2:0] cur);
        op_next = cur + 3'd1;
    endfunction

    // Saturating increment so a long stable level can never wrap the count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_SAT) begin
            sat_inc = CNT_SAT;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic         click_meta_r;
    logic         click_s_r;
    logic [N-1:0] in1_meta_r;
    logic [N-1:0] in2_meta_r;
    logic [1:0]   vld_r;
    logic         armed_r;
    state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic         repeat_hit_s;

    // Two-flop synchronisers for the button and switches, plus a marker that
    // says when the synchroniser pipeline holds real samples after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            click_meta_r <= 1'b0;
            click_s_r    <= 1'b0;
            in1_meta_r   <= {N{1'b0}};
            in2_meta_r   <= {N{1'b0}};
            in1          <= {N{1'b0}};
            in2          <= {N{1'b0}};
            vld_r        <= 2'b00;
        end else begin
            click_meta_r <= click_raw;
            click_s_r    <= click_meta_r;
            in1_meta_r   <= in1_raw;
            in2_meta_r   <= in2_raw;
            in1          <= in1_meta_r;
            in2          <= in2_meta_r;
            vld_r        <= {vld_r[0], 1'b1};
        end
    end

`ifdef ALU_OP_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rcnt_r;

    assign repeat_hit_s = (state_r == HELD) && click_s_r && (rcnt_r >= RP_LAST);

    // Hold-time counter: runs only while the button stays held, restarts
    // after each repeat step and whenever HELD is left.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt_r <= CNT_ZERO;
        end else if ((state_r == HELD) && click_s_r && !repeat_hit_s) begin
            rcnt_r <= sat_inc(rcnt_r);
        end else begin
            rcnt_r <= CNT_ZERO;
        end
    end
`else
    assign repeat_hit_s = 1'b0;
`endif

    // Debounce FSM with registered op, op_step and busy. A press is only
    // armed once the synchronised button has been seen released after reset,
    // so a button held through reset never produces a step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            armed_r <= 1'b0;
            op      <= 3'd0;
            op_step <= 1'b0;
            busy    <= 1'b0;
        end else begin
            op_step <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (!armed_r) begin
                        armed_r <= vld_r[1] & ~click_s_r;
                        busy    <= 1'b0;
                    end else if (click_s_r) begin
                        state_r <= PRESS_WAIT;
                        cnt_r   <= CNT_ONE;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                PRESS_WAIT: begin
                    if (!click_s_r) begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                        busy    <= 1'b0;
                    end else if (cnt_r >= DB_LAST) begin
                        state_r <= HELD;
                        cnt_r   <= CNT_ZERO;
                        op      <= op_next(op);
                        op_step <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        cnt_r   <= sat_inc(cnt_r);
                        busy    <= 1'b1;
                    end
                end
                HELD: begin
                    busy <= 1'b1;
                    if (!click_s_r) begin
                        state_r <= RELEASE_WAIT;
                        cnt_r   <= CNT_ONE;
                    end else if (repeat_hit_s) begin
                        cnt_r   <= CNT_ZERO;
                        op      <= op_next(op);
                        op_step <= 1'b1;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                    end
                end
                RELEASE_WAIT: begin
                    if (click_s_r) begin
                        state_r <= HELD;
                        cnt_r   <= CNT_ZERO;
                        busy    <= 1'b1;
                    end else if (cnt_r >= DB_LAST) begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                        busy    <= 1'b0;
                    end else begin
                        cnt_r   <= sat_inc(cnt_r);
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
